arch_map_table: RTL and testbench
=================================

# arch_map_table

Architectural map table at the retire end of rename. Each committing instruction with a destination writes its new physical register into the logical→physical table. The physical register it displaces is returned to the speculative free list on the free list's commit push port (commitValidN_i / commitRegN_i). The full committed table is exported so the rename map table can be restored on recovery.

## Interface
Parameters:
- COMMIT_WIDTH, 4, retire slots per cycle; slot 0 is oldest.
- NUM_LOG_REGS, 34, architectural registers.
- LOG_REG_W, 6, logical register index width.
- PHYS_REG_W, 7, physical register tag width; equals free-list SIZE_PHYSICAL_LOG.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- commitValid_i  in  COMMIT_WIDTH  slot N is retiring this cycle.
- commitHasDest_i  in  COMMIT_WIDTH  slot N writes a destination.
- commitLogDest0..3_i  in  LOG_REG_W each  logical destination of slot N.
- commitPhyDest0..3_i  in  PHYS_REG_W each  physical destination of slot N.
- freedValid0..3_o  out  1 each  slot N releases a register; drives free-list commitValidN_i.
- freedReg0..3_o  out  PHYS_REG_W each  released tag; drives free-list commitRegN_i.
- amtFlat_o  out  NUM_LOG_REGS*PHYS_REG_W  committed table; entry i at bits [i*PHYS_REG_W +: PHYS_REG_W].
- commitCnt_o  out  32  count of retired destination-writing instructions; wraps.

## Operation
- Slot N is effective when commitValid_i[N] & commitHasDest_i[N]. Non-effective slots do nothing: no table write, no freed output.
- Freed tag for effective slot N:
  - if an older effective slot M<N in the same cycle has the same logical destination, the freed tag is the phys dest of the youngest such M (in-group bypass);
  - otherwise it is amt[commitLogDestN_i] as held before this edge.
- Table write: for each logical register, the youngest effective slot targeting it wins. Older same-register writes are dropped and covered by the bypass above.
- Slots need not be contiguous; each slot is resolved independently by the rules above.
- No stall input. The commit stage issues retires only when downstream can accept them, and the free list always accepts pushes.
- commitCnt_o increases by the popcount of effective slots each cycle, modulo 2^32.

## Timing
- Reset (async assert, applies immediately):
  - amt[i] = i;
  - freedValid*_o = 0, freedReg*_o = 0;
  - commitCnt_o = 0.
  - The free list's initial contents must therefore hold tags NUM_LOG_REGS and above.
- Table update: commit in cycle T is visible on amtFlat_o in cycle T+1. amtFlat_o is a direct view of the registers, with no extra stage.
- Freed outputs: registered, one-cycle latency. Commit in T gives freedValid/freedReg in T+1; the free list pushes at the T+1 edge.
- Back-to-back commits: full throughput. A cycle-T commit reads the table as updated by cycle T-1.
- Recovery: none internally. A recovering consumer samples amtFlat_o in the cycle after the last commit. Frees already registered are still delivered.
- Reset mid-operation: pending freed outputs are discarded and the table returns to identity. Colleagues must reset the free list in the same cycle.

## Structure
- Shared package holds COMMIT_WIDTH, NUM_LOG_REGS, LOG_REG_W and PHYS_REG_W as constants, plus a commit-slot struct {valid, hasDest, logDest, phyDest}. The free list and active list use the same package.
- One sub-module, amt_group_resolve, purely combinational:
  - inputs: the four commit slots and the four current table read values;
  - outputs: per-slot freed tag/valid and per-slot "is youngest writer" write enables.
- Top level holds the table registers (4 read ports, 4 write ports with priority to the youngest), the freed-output registers and the counter.

## Test plan
- Reset, then read amtFlat_o -> entry i = i for i=0..33; all freedValid = 0; commitCnt_o = 0.
- Slot0 valid+dest, log 5, phy 40 -> next cycle freedValid0=1, freedReg0=5; amt[5]=40; commitCnt_o=1.
- Same cycle: slot0 log 3 phy 50; slot1 log 3 phy 51; slot2 log 3 phy 52 -> freed tags 3, 50, 51; amt[3]=52.
- Slot1 valid with hasDest=0, slot3 log 7 phy 60 -> freedValid1=0, freedValid3=1 with freedReg3=7; amt[7]=60; other entries unchanged.
- Back-to-back: cycle T log 9 phy 70, cycle T+1 log 9 phy 71 -> frees 9 then 70 on consecutive cycles; amt[9]=71.
- Assert reset asynchronously while freedValid0=1 -> freedValid0 drops to 0 before the next clock edge; table returns to identity.

Source files
------------

// File: rtl/arch_map_table_pkg.sv
// arch_map_table_pkg: shared rename/retire constants and the commit-slot record
package arch_map_table_pkg;
  localparam int COMMIT_WIDTH = 4;
  localparam int NUM_LOG_REGS = 34;
  localparam int LOG_REG_W = 6;
  localparam int PHYS_REG_W = 7;
  typedef struct packed {
    logic valid;
    logic has_dest;
    logic [LOG_REG_W-1:0] log_dest;
    logic [PHYS_REG_W-1:0] phy_dest;
  } commit_slot_t;
endpackage

// File: rtl/arch_map_table_if.sv
// arch_map_table_if: retire commit slots in, freed tags / committed table / retire count out
interface arch_map_table_if;
  import arch_map_table_pkg::*;
  logic [COMMIT_WIDTH-1:0] commitValid_i;
  logic [COMMIT_WIDTH-1:0] commitHasDest_i;
  logic [LOG_REG_W-1:0] commitLogDest0_i, commitLogDest1_i, commitLogDest2_i, commitLogDest3_i;
  logic [PHYS_REG_W-1:0] commitPhyDest0_i, commitPhyDest1_i, commitPhyDest2_i, commitPhyDest3_i;
  logic freedValid0_o, freedValid1_o, freedValid2_o, freedValid3_o;
  logic [PHYS_REG_W-1:0] freedReg0_o, freedReg1_o, freedReg2_o, freedReg3_o;
  logic [NUM_LOG_REGS*PHYS_REG_W-1:0] amtFlat_o;
  logic [31:0] commitCnt_o;
  modport master (
    output commitValid_i, commitHasDest_i,
    output commitLogDest0_i, commitLogDest1_i, commitLogDest2_i, commitLogDest3_i,
    output commitPhyDest0_i, commitPhyDest1_i, commitPhyDest2_i, commitPhyDest3_i,
    input freedValid0_o, freedValid1_o, freedValid2_o, freedValid3_o,
    input freedReg0_o, freedReg1_o, freedReg2_o, freedReg3_o,
    input amtFlat_o, commitCnt_o
  );
  modport slave (
    input commitValid_i, commitHasDest_i,
    input commitLogDest0_i, commitLogDest1_i, commitLogDest2_i, commitLogDest3_i,
    input commitPhyDest0_i, commitPhyDest1_i, commitPhyDest2_i, commitPhyDest3_i,
    output freedValid0_o, freedValid1_o, freedValid2_o, freedValid3_o,
    output freedReg0_o, freedReg1_o, freedReg2_o, freedReg3_o,
    output amtFlat_o, commitCnt_o
  );
endinterface

// File: rtl/amt_group_resolve.sv
// amt_group_resolve: per-slot freed tag (with in-group bypass) and youngest-writer write enables
// ports: slot/rd in (commit slots, table reads); freed_reg/freed_valid/we out
module amt_group_resolve
  import arch_map_table_pkg::*;
(
  input  commit_slot_t slot [COMMIT_WIDTH],
  input  logic [PHYS_REG_W-1:0] rd [COMMIT_WIDTH],
  output logic [PHYS_REG_W-1:0] freed_reg [COMMIT_WIDTH],
  output logic [COMMIT_WIDTH-1:0] freed_valid,
  output logic [COMMIT_WIDTH-1:0] we
);
  always_comb begin
    for (int n = 0; n < COMMIT_WIDTH; n++) freed_valid[n] = slot[n].valid & slot[n].has_dest;
    for (int n = 0; n < COMMIT_WIDTH; n++) begin
      freed_reg[n] = rd[n];
      we[n] = freed_valid[n];
      // ascending scan so the youngest older match overrides earlier ones
      for (int m = 0; m < n; m++)
        if (freed_valid[m] && slot[m].log_dest == slot[n].log_dest) freed_reg[n] = slot[m].phy_dest;
      for (int m = n + 1; m < COMMIT_WIDTH; m++)
        if (freed_valid[m] && slot[m].log_dest == slot[n].log_dest) we[n] = 1'b0;
    end
  end
endmodule

// File: rtl/arch_map_table.sv
// arch_map_table: committed logical->physical table; returns displaced tags to the free list
// ports: clk, reset (async high), b (slave: commit slots in, freed tags/table/count out)
module arch_map_table
  import arch_map_table_pkg::*;
(
  input logic clk,
  input logic reset,
  arch_map_table_if.slave b
);
  commit_slot_t slot [COMMIT_WIDTH];
  logic [PHYS_REG_W-1:0] amt [NUM_LOG_REGS];
  logic [PHYS_REG_W-1:0] rd [COMMIT_WIDTH];
  logic [PHYS_REG_W-1:0] freed_reg [COMMIT_WIDTH];
  logic [PHYS_REG_W-1:0] freed_reg_q [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] freed_valid, we, freed_valid_q;
  logic [31:0] cnt;
  always_comb begin
    slot[0] = '{b.commitValid_i[0], b.commitHasDest_i[0], b.commitLogDest0_i, b.commitPhyDest0_i};
    slot[1] = '{b.commitValid_i[1], b.commitHasDest_i[1], b.commitLogDest1_i, b.commitPhyDest1_i};
    slot[2] = '{b.commitValid_i[2], b.commitHasDest_i[2], b.commitLogDest2_i, b.commitPhyDest2_i};
    slot[3] = '{b.commitValid_i[3], b.commitHasDest_i[3], b.commitLogDest3_i, b.commitPhyDest3_i};
    for (int n = 0; n < COMMIT_WIDTH; n++)
      rd[n] = slot[n].log_dest < LOG_REG_W'(NUM_LOG_REGS) ? amt[slot[n].log_dest] : '0;
  end
  amt_group_resolve u_resolve (.slot(slot), .rd(rd), .freed_reg(freed_reg), .freed_valid(freed_valid), .we(we));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOG_REGS; i++) amt[i] <= PHYS_REG_W'(i);
      for (int n = 0; n < COMMIT_WIDTH; n++) freed_reg_q[n] <= '0;
      freed_valid_q <= '0;
      cnt <= '0;
    end else begin
      // write enables are unique per logical register, so slot order is irrelevant here
      for (int n = 0; n < COMMIT_WIDTH; n++)
        if (we[n] && slot[n].log_dest < LOG_REG_W'(NUM_LOG_REGS)) amt[slot[n].log_dest] <= slot[n].phy_dest;
      for (int n = 0; n < COMMIT_WIDTH; n++) freed_reg_q[n] <= freed_valid[n] ? freed_reg[n] : '0;
      freed_valid_q <= freed_valid;
      cnt <= cnt + 32'($countones(freed_valid));
    end
  end
  for (genvar i = 0; i < NUM_LOG_REGS; i++) assign b.amtFlat_o[i*PHYS_REG_W +: PHYS_REG_W] = amt[i];
  assign b.freedValid0_o = freed_valid_q[0];
  assign b.freedValid1_o = freed_valid_q[1];
  assign b.freedValid2_o = freed_valid_q[2];
  assign b.freedValid3_o = freed_valid_q[3];
  assign b.freedReg0_o = freed_reg_q[0];
  assign b.freedReg1_o = freed_reg_q[1];
  assign b.freedReg2_o = freed_reg_q[2];
  assign b.freedReg3_o = freed_reg_q[3];
  assign b.commitCnt_o = cnt;
endmodule

// File: tb/tb_arch_map_table.sv
// tb_arch_map_table: directed plus random retire traffic checked against a sequential table model
module tb_arch_map_table;
  import arch_map_table_pkg::*;
  localparam int FW = NUM_LOG_REGS * PHYS_REG_W;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  arch_map_table_if b ();
  arch_map_table dut (.clk(clk), .reset(reset), .b(b.slave));
  int errors = 0;
  int checks = 0;
  int unsigned mamt [NUM_LOG_REGS];
  logic [31:0] mcnt;
  logic v [4], h [4];
  logic [LOG_REG_W-1:0] l [4];
  logic [PHYS_REG_W-1:0] p [4];
  logic ev [4];
  logic [PHYS_REG_W-1:0] er [4];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NUM_LOG_REGS; i++) f[i*PHYS_REG_W +: PHYS_REG_W] = PHYS_REG_W'(mamt[i]);
    return f;
  endfunction

  function automatic logic fv(input int n);
    return n == 0 ? b.freedValid0_o : n == 1 ? b.freedValid1_o : n == 2 ? b.freedValid2_o : b.freedValid3_o;
  endfunction

  function automatic logic [PHYS_REG_W-1:0] fr(input int n);
    return n == 0 ? b.freedReg0_o : n == 1 ? b.freedReg1_o : n == 2 ? b.freedReg2_o : b.freedReg3_o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LOG_REGS; i++) mamt[i] = i;
    mcnt = 0;
  endtask

  task automatic clear_slots();
    for (int n = 0; n < 4; n++) begin
      v[n] = 0; h[n] = 0; l[n] = 0; p[n] = 0;
    end
  endtask

  // Retirement in program order: each retiring writer frees whatever the
  // table held for its register at that moment, then installs its own tag.
  task automatic cycle(input string tag);
    b.commitValid_i = {v[3], v[2], v[1], v[0]};
    b.commitHasDest_i = {h[3], h[2], h[1], h[0]};
    b.commitLogDest0_i = l[0]; b.commitLogDest1_i = l[1];
    b.commitLogDest2_i = l[2]; b.commitLogDest3_i = l[3];
    b.commitPhyDest0_i = p[0]; b.commitPhyDest1_i = p[1];
    b.commitPhyDest2_i = p[2]; b.commitPhyDest3_i = p[3];
    for (int n = 0; n < 4; n++) begin
      ev[n] = v[n] & h[n];
      er[n] = '0;
      if (ev[n]) begin
        er[n] = PHYS_REG_W'(mamt[l[n]]);
        mamt[l[n]] = p[n];
        mcnt++;
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s freedValid%0d", tag, n), FW'(fv(n)), FW'(ev[n]));
      if (ev[n]) chk($sformatf("%s freedReg%0d", tag, n), FW'(fr(n)), FW'(er[n]));
    end
    chk({tag, " amtFlat"}, b.amtFlat_o, model_flat());
    chk({tag, " commitCnt"}, FW'(b.commitCnt_o), FW'(mcnt));
    clear_slots();
  endtask

  task automatic check_idle(input string tag);
    for (int n = 0; n < 4; n++) chk($sformatf("%s freedValid%0d", tag, n), FW'(fv(n)), '0);
    chk({tag, " amtFlat"}, b.amtFlat_o, model_flat());
    chk({tag, " commitCnt"}, FW'(b.commitCnt_o), FW'(mcnt));
  endtask

  initial begin
    clear_slots();
    model_reset();
    b.commitValid_i = '0;
    b.commitHasDest_i = '0;
    b.commitLogDest0_i = '0; b.commitLogDest1_i = '0; b.commitLogDest2_i = '0; b.commitLogDest3_i = '0;
    b.commitPhyDest0_i = '0; b.commitPhyDest1_i = '0; b.commitPhyDest2_i = '0; b.commitPhyDest3_i = '0;
    reset = 1'b1;
    #12 reset = 1'b0;
    check_idle("reset");
    v[0] = 1; h[0] = 1; l[0] = 5; p[0] = 40;
    cycle("single");
    for (int n = 0; n < 3; n++) begin
      v[n] = 1; h[n] = 1; l[n] = 3; p[n] = PHYS_REG_W'(50 + n);
    end
    cycle("bypass");
    v[1] = 1; h[1] = 0; l[1] = 8; p[1] = 90;
    v[3] = 1; h[3] = 1; l[3] = 7; p[3] = 60;
    cycle("nodest");
    v[0] = 1; h[0] = 1; l[0] = 9; p[0] = 70;
    cycle("b2b_a");
    v[0] = 1; h[0] = 1; l[0] = 9; p[0] = 71;
    cycle("b2b_b");
    cycle("idle");
    v[0] = 1; h[0] = 1; l[0] = 11; p[0] = 99;
    cycle("pre_reset");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_idle("async_reset");
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      for (int n = 0; n < 4; n++) begin
        v[n] = ($urandom_range(0, 3) != 0);
        h[n] = ($urandom_range(0, 4) != 0);
        l[n] = LOG_REG_W'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NUM_LOG_REGS - 1));
        p[n] = PHYS_REG_W'($urandom);
      end
      cycle($sformatf("rand%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
